// File: rtl/s_box_layer_fold.sv
// Folded AES S-box layer: one NBYTES-byte block is substituted in place,
// LANES bytes per cycle, behind a valid/ready handshake on both sides.

module s_box_lut (
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = product of a^(2^i), i=1..7; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] pre;
    logic [7:0] g;

    // Both directions share one field inverter; the affine maps sit on either side.
    always_comb begin
        pre = din;
        if (inv) pre = rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05;
        g    = gf_inv(pre);
        dout = g;
        if (!inv) dout = g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
    end

endmodule

module s_box_layer_fold #(
    parameter int NBYTES = 16,
    parameter int LANES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic [8*NBYTES-1:0] RKO,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] SBO
);

    localparam int N  = NBYTES / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (NBYTES < 1 || LANES < 1 || (NBYTES % LANES) != 0) begin : g_bad_params
        $error("s_box_layer_fold: LANES must divide NBYTES");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [8*NBYTES-1:0] data_q, data_d;
    logic                mode_q, mode_d;

    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_in[gi] = data_q[8*(int'(cnt_q)*LANES + gi) +: 8];

        s_box_lut u_lut (
            .din  (lane_in[gi]),
            .inv  (mode_q),
            .dout (lane_out[gi])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        mode_d    = mode_q;
        in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
        out_valid = (state_q == DONE);

        case (state_q)
            RUN: begin
                for (int j = 0; j < LANES; j++) begin
                    data_d[8*(int'(cnt_q)*LANES + j) +: 8] = lane_out[j];
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // Accepting overrides the IDLE/DONE transitions above, giving the DONE->RUN bypass.
        if (in_valid && in_ready) begin
            data_d  = RKO;
            mode_d  = mode;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign SBO = data_q;

endmodule

// File: doc/s_box_layer_fold.md
# s_box_layer_fold

Folded, handshaked successor of the 16-lane combinational S-box layer. The block holds one state block of `NBYTES` bytes and substitutes it with `LANES` `s_box_lut` instances per cycle, finishing a block in `NBYTES/LANES` cycles. It sits between the round-key-add stage (`RKO`) and the linear layer (`SBO`) and lets area-constrained builds trade S-box instances for latency. `mode` selects the table per block: 0 = AES forward S-box, 1 = AES inverse S-box, both as implemented by `s_box_lut`.

## Interface
Parameters:
- `NBYTES`, default 16: bytes per block. Must be ≥1.
- `LANES`, default 4: `s_box_lut` instances. Must divide `NBYTES`; elaboration fails otherwise.

Ports:
- `clk`, in, 1: the single clock, rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `in_valid`, in, 1: `RKO`/`mode` valid.
- `in_ready`, out, 1: block can accept an input.
- `mode`, in, 1: table select, captured with the block.
- `RKO`, in, 8*NBYTES: input block; byte i is `RKO[8i+7:8i]`.
- `out_valid`, out, 1: `SBO` holds a finished block.
- `out_ready`, in, 1: consumer accepts `SBO`.
- `SBO`, out, 8*NBYTES: substituted block, same byte order as `RKO`.

## Operation
- Let `N = NBYTES/LANES`. Chunk counter `cnt` is `max(1,clog2(N))` bits wide and runs 0..N-1.
- FSM has three states:
  - IDLE: `in_ready`=1. On `in_valid`: latch `RKO` into the data register and `mode` into the mode register, set `cnt`=0, go to RUN.
  - RUN: lane j substitutes byte `cnt*LANES+j` of the data register using the latched mode. The result is written back in place; other bytes are unchanged. At `cnt`=N-1 go to DONE, else `cnt`+1.
  - DONE: `out_valid`=1 and `SBO` = data register.
    - On `out_ready` without `in_valid`: go to IDLE.
    - On `out_ready` with `in_valid` (`in_ready`=1 in that case): latch the new block and go straight to RUN.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready). This is combinational from `out_ready`.
- Inputs outside an accepting handshake are ignored. `RKO` and `mode` may change freely during RUN and DONE.
- `SBO` is stable while `out_valid`=1 and not yet accepted.
- `SBO` outside DONE shows the data register (partially substituted during RUN). The consumer must qualify it with `out_valid`.
- The latched `mode` applies to the whole block; changing the `mode` input mid-block has no effect.
- Reset (any state, including mid-RUN or mid-DONE): state=IDLE, `cnt`=0, data register=0, mode register=0. The in-flight block is discarded. Nothing is emitted after reset is released unless a new block is accepted.

## Timing
Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `SBO`=0.

- Latency: input accepted at edge k → `out_valid`=1 after edge k+N. That is exactly N cycles: 4 for the defaults, 1 for `LANES`=`NBYTES`, 16 for `LANES`=1.
- Throughput with `out_ready` held high: one block every N+1 cycles, using the DONE→RUN bypass.
- Back-pressure: DONE holds indefinitely while `out_ready`=0, and `in_ready`=0 during that time.
- Output is registered. The S-box path is a single `s_box_lut` per lane between register stages.

## Test plan
- Default params; `RKO`=all 0x00, `mode`=0, accept at cycle 0 → `out_valid` rises after 4 edges with `SBO`=all 0x63. With `out_ready`=1, returns to IDLE next edge.
- `RKO` byte i = i (0x00..0x0F), `mode`=0 → `SBO` byte0=0x63, byte1=0x7C, byte2=0x77, byte15=0x76. Repeat with `mode`=1 on that output → original 0x00..0x0F recovered. Change `mode` mid-RUN → result unaffected.
- Back-pressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 and a different `RKO` → `in_ready`=0 throughout, `SBO` constant. Raise `out_ready` → the new block is accepted on the same edge and its `out_valid` appears 4 edges later.
- Streaming: `in_valid`=`out_ready`=1 continuously with 8 random blocks → 8 outputs at a 5-cycle period, in order, each matching a byte-wise AES S-box model.
- Reset asserted during RUN at `cnt`=2 → next cycle `out_valid`=0, `in_ready`=1, `SBO`=0. No spurious output for 10 cycles afterwards.
- Param sweep (`NBYTES`,`LANES`) ∈ {(16,16),(16,1),(8,2),(1,1)} → latency = `NBYTES/LANES` and results match the model for random blocks, both modes.
